// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus sequencer and its phase tick counter.
package rtc_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WAIT_LISTO,
      DONE
   } seq_state_t;

   localparam logic [3:0] PHASE_LAST  = 4'd11;
   localparam logic [2:0] MODE_STATUS = 3'd1;
   localparam int         ENABLE_W    = 3;

   // Bit positions inside the one-hot enable vector.
   localparam int EN_INIT  = 0;
   localparam int EN_WRITE = 1;
   localparam int EN_READ  = 2;

   // Fixed priority init > write > read; lower requests are dropped.
   function automatic logic [ENABLE_W-1:0] pick_enable(input logic init_i,
                                                        input logic write_i,
                                                        input logic read_i);
      logic [ENABLE_W-1:0] en;
      en = '0;
      if (init_i)       en[EN_INIT]  = 1'b1;
      else if (write_i) en[EN_WRITE] = 1'b1;
      else if (read_i)  en[EN_READ]  = 1'b1;
      return en;
   endfunction

endpackage

// File: rtl/rtc_phase_tick.sv
// Per-phase tick counter: counts 0..TICKS-1 while enabled and pulses wrap_o on the last tick.
module rtc_phase_tick #(
   parameter int unsigned TICKS = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic wrap_o
);

   localparam logic [7:0] TICK_LAST = 8'(TICKS - 1);

   logic [7:0] tick_q;
   logic [7:0] tick_d;

   assign wrap_o = en_i && (tick_q == TICK_LAST);

   always_comb begin
      // NOTE: default first so every path assigns tick_d and no latch is inferred.
      tick_d = tick_q;
      if (clear_i)   tick_d = '0;
      else if (en_i) tick_d = wrap_o ? '0 : tick_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
      if (!reset) tick_q <= '0;
      else        tick_q <= tick_d;
   end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Upstream sequencer for the RTC bus timing generator: accepts one request, steps phase 0..11,
// closes on listo. Define RTC_SEQ_TIMEOUT_EN to add the listo watchdog and err_tmo pulse.
module rtc_bus_sequencer
   import rtc_bus_pkg::*;
#(
   parameter int unsigned TICKS_PER_PHASE = 10,
   parameter int unsigned TMO_CYCLES      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_init,
   input  logic       req_write,
   input  logic       req_read,
   input  logic [2:0] req_mode,
   input  logic [7:0] addr_in,
   input  logic [7:0] wdata_in,
   input  logic       listo,
   output logic [3:0] estado,
   output logic       enable_inicio,
   output logic       enable_escribir,
   output logic       enable_leer,
   output logic [2:0] Estado_m,
   output logic [7:0] addr_q,
   output logic [7:0] wdata_q,
   output logic       busy,
   output logic       done,
   output logic       err_tmo
);

   if (TICKS_PER_PHASE < 2 || TICKS_PER_PHASE > 255) begin : g_bad_ticks
      $error("TICKS_PER_PHASE must be 2..255");
   end
   if (TMO_CYCLES < 1 || TMO_CYCLES > 255) begin : g_bad_tmo
      $error("TMO_CYCLES must be 1..255");
   end

   seq_state_t          state_q, state_d;
   logic [3:0]          estado_q, estado_d;
   logic [ENABLE_W-1:0] en_q, en_d;
   logic [2:0]          mode_d;
   logic [7:0]          addr_d, wdata_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                phase_wrap;
   logic                close_txn;

`ifdef RTC_SEQ_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);
   logic [7:0] wd_q, wd_d;
   logic       err_q, err_d;
`endif

   rtc_phase_tick #(
      .TICKS (TICKS_PER_PHASE)
   ) u_tick (
      .clk     (clk),
      .reset   (reset),
      .clear_i (state_q != RUN),
      .en_i    (state_q == RUN),
      .wrap_o  (phase_wrap)
   );

   always_comb begin
      state_d   = state_q;
      estado_d  = estado_q;
      en_d      = en_q;
      mode_d    = Estado_m;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      close_txn = 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
      err_d     = 1'b0;
      wd_d      = (state_q == WAIT_LISTO) ? wd_q + 8'd1 : '0;
`endif

      case (state_q)
         IDLE: begin
            if (req_init || req_write || req_read) begin
               state_d  = RUN;
               en_d     = pick_enable(req_init, req_write, req_read);
               mode_d   = req_mode;
               addr_d   = addr_in;
               wdata_d  = wdata_in;
               busy_d   = 1'b1;
               estado_d = '0;
            end
         end
         RUN: begin
            if (phase_wrap) begin
               if (estado_q < PHASE_LAST) estado_d = estado_q + 4'd1;
               else                       state_d  = WAIT_LISTO;
            end
         end
         WAIT_LISTO: begin
            // listo is checked first so it wins over a coincident timeout.
            if (listo) close_txn = 1'b1;
`ifdef RTC_SEQ_TIMEOUT_EN
            else if (wd_q == TMO_LAST) begin
               close_txn = 1'b1;
               err_d     = 1'b1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (close_txn) begin
         state_d  = DONE;
         done_d   = 1'b1;
         en_d     = '0;
         busy_d   = 1'b0;
         estado_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         estado_q <= '0;
         en_q     <= '0;
         Estado_m <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef RTC_SEQ_TIMEOUT_EN
         wd_q     <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         estado_q <= estado_d;
         en_q     <= en_d;
         Estado_m <= mode_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef RTC_SEQ_TIMEOUT_EN
         wd_q     <= wd_d;
         err_q    <= err_d;
`endif
      end
   end

   assign estado          = estado_q;
   assign enable_inicio   = en_q[EN_INIT];
   assign enable_escribir = en_q[EN_WRITE];
   assign enable_leer     = en_q[EN_READ];
   assign busy            = busy_q;
   assign done            = done_q;
`ifdef RTC_SEQ_TIMEOUT_EN
   assign err_tmo         = err_q;
`else
   assign err_tmo         = 1'b0;
`endif

endmodule
